rom_req_arbiter: RTL and testbench

- Sits directly downstream of the tile/sprite ROM caches and upstream of the SDRAM controller's ROM read channel.
- Collects level-held miss requests (rom_req/rom_addr) from three cache clients.
- Round-robin arbitrates them onto a single SDRAM read port, adding a per-client region base.
- Returns the 32-bit word with a one-cycle valid pulse to the winning client.

---
 rtl/rom_req_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rom_req_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_req_arbiter.sv
// rom_req_arbiter
//
// Round-robin arbiter between three ROM cache clients and the SDRAM
// controller's ROM read channel. Each client holds rom_req high with an
// address until its data comes back; the arbiter adds a per-client SDRAM
// region base, issues one read at a time, and returns the 32-bit word with
// a single-cycle valid pulse to the client that was served.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   client_req    per-client level request (3 bits)
//   client_addr   packed client addresses, client n at [n*ADDR_W +: ADDR_W]
//   client_data   registered read data, shared by all clients
//   client_valid  one-hot single-cycle data-valid pulse
//   sdram_req     level read request, held until sdram_ack
//   sdram_addr    SDRAM word address, stable while sdram_req is high
//   sdram_data    SDRAM read data, valid with sdram_ack
//   sdram_ack     single-cycle completion pulse

module rom_req_arbiter #(
    parameter int                   ADDR_W    = 20,
    parameter int                   SD_ADDR_W = 24,
    parameter logic [SD_ADDR_W-1:0] BASE0     = 24'h000000,
    parameter logic [SD_ADDR_W-1:0] BASE1     = 24'h100000,
    parameter logic [SD_ADDR_W-1:0] BASE2     = 24'h200000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            client_req,
    input  logic [3*ADDR_W-1:0]   client_addr,
    output logic [31:0]           client_data,
    output logic [2:0]            client_valid,
    output logic                  sdram_req,
    output logic [SD_ADDR_W-1:0]  sdram_addr,
    input  logic [31:0]           sdram_data,
    input  logic                  sdram_ack
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rr_q, rr_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [ADDR_W-1:0]      lat_addr_q, lat_addr_d;
    logic [2:0]             served_q, served_d;
    logic [ADDR_W-1:0]      last_addr_q [0:2];
    logic [ADDR_W-1:0]      last_addr_d [0:2];
    logic                   sdram_req_d;
    logic [SD_ADDR_W-1:0]   sdram_addr_d;
    logic [31:0]            client_data_d;
    logic [2:0]             client_valid_d;

    logic [ADDR_W-1:0]      cur_addr [0:2];
    logic [2:0]             eligible;
    logic                   found;
    logic [1:0]             pick;
    logic [2:0]             cand;
    logic [ADDR_W-1:0]      pick_addr;
    logic [SD_ADDR_W-1:0]   pick_base;
    logic                   gnt_match;

    // A client whose current request was already answered stays ineligible
    // until it drops rom_req or moves to a new address, because the caches
    // keep rom_req asserted after the data arrives.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cur_addr[i] = client_addr[i*ADDR_W +: ADDR_W];
            eligible[i] = client_req[i] &&
                          !(served_q[i] && (cur_addr[i] == last_addr_q[i]));
        end
    end

    // Search starts at the round-robin pointer and wraps 2 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        cand  = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, rr_q} + 3'(i);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && eligible[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        pick_base = '0;
        gnt_match = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (pick == 2'(i)) pick_addr = cur_addr[i];
            if (gnt_q == 2'(i))
                gnt_match = client_req[i] && (cur_addr[i] == lat_addr_q);
        end
        case (pick)
            2'd0:    pick_base = BASE0;
            2'd1:    pick_base = BASE1;
            default: pick_base = BASE2;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= 2'd0;
            gnt_q        <= 2'd0;
            lat_addr_q   <= '0;
            served_q     <= 3'b000;
            last_addr_q  <= '{default: '0};
            sdram_req    <= 1'b0;
            sdram_addr   <= '0;
            client_data  <= 32'd0;
            client_valid <= 3'b000;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            lat_addr_q   <= lat_addr_d;
            served_q     <= served_d;
            last_addr_q  <= last_addr_d;
            sdram_req    <= sdram_req_d;
            sdram_addr   <= sdram_addr_d;
            client_data  <= client_data_d;
            client_valid <= client_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        gnt_d          = gnt_q;
        lat_addr_d     = lat_addr_q;
        served_d       = served_q;
        last_addr_d    = last_addr_q;
        sdram_req_d    = sdram_req;
        sdram_addr_d   = sdram_addr;
        client_data_d  = client_data;
        client_valid_d = 3'b000;

        for (int i = 0; i < 3; i++) begin
            if (!client_req[i]) served_d[i] = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // sdram_ack is deliberately ignored here so a stray ack left
                // over from an interrupted transaction does nothing.
                if (found) begin
                    gnt_d        = pick;
                    lat_addr_d   = pick_addr;
                    sdram_addr_d = pick_base + SD_ADDR_W'(pick_addr);
                    sdram_req_d  = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sdram_ack) begin
                    sdram_req_d   = 1'b0;
                    client_data_d = sdram_data;
                    // Data is only delivered if the client still wants that
                    // exact word; a withdrawn or re-addressed request is dropped.
                    if (gnt_match) begin
                        for (int i = 0; i < 3; i++) begin
                            if (gnt_q == 2'(i)) begin
                                client_valid_d[i] = 1'b1;
                                served_d[i]       = 1'b1;
                                last_addr_d[i]    = lat_addr_q;
                            end
                        end
                    end
                    rr_d    = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_req_arbiter.sv
// tb_rom_req_arbiter
//
// Bench for rom_req_arbiter. Expected client responses are queued when an
// ack is driven and checked by a monitor whenever client_valid pulses. A
// second instance with a high BASE2 exercises SDRAM address wrap-around.

module tb_rom_req_arbiter;

    localparam int ADDR_W    = 20;
    localparam int SD_ADDR_W = 24;
    localparam logic [23:0] B0 = 24'h000000;
    localparam logic [23:0] B1 = 24'h100000;
    localparam logic [23:0] B2 = 24'h200000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  client_req;
    logic [59:0] client_addr;
    logic [31:0] client_data;
    logic [2:0]  client_valid;
    logic        sdram_req;
    logic [23:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_ack;

    logic [2:0]  w_req;
    logic [59:0] w_addr;
    logic [31:0] w_cdata;
    logic [2:0]  w_valid;
    logic        w_sreq;
    logic [23:0] w_saddr;
    logic [31:0] w_sdata;
    logic        w_sack;

    typedef struct packed {
        logic [2:0]  valid;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_valid = 3'b000;

    always #5 clk = ~clk;

    rom_req_arbiter #(
        .ADDR_W(ADDR_W), .SD_ADDR_W(SD_ADDR_W),
        .BASE0(B0), .BASE1(B1), .BASE2(B2)
    ) dut (
        .clk(clk), .reset(reset),
        .client_req(client_req), .client_addr(client_addr),
        .client_data(client_data), .client_valid(client_valid),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_data(sdram_data), .sdram_ack(sdram_ack)
    );

    rom_req_arbiter #(
        .ADDR_W(ADDR_W), .SD_ADDR_W(SD_ADDR_W),
        .BASE0(B0), .BASE1(B1), .BASE2(24'hFFFFF0)
    ) dut_wrap (
        .clk(clk), .reset(reset),
        .client_req(w_req), .client_addr(w_addr),
        .client_data(w_cdata), .client_valid(w_valid),
        .sdram_req(w_sreq), .sdram_addr(w_saddr),
        .sdram_data(w_sdata), .sdram_ack(w_sack)
    );

    // Scoreboard monitor: every valid pulse must match the oldest queued
    // expectation, and no two pulses may be back to back.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset) begin
            if (client_valid !== 3'b000) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sb_unexpected: client_valid=%b data=%h, required no pulse",
                             client_valid, client_data);
                end else begin
                    e = exp_q.pop_front();
                    if (client_valid !== e.valid || client_data !== e.data) begin
                        bad++;
                        $display("[TB] FAIL sb_response: valid=%b data=%h, required valid=%b data=%h",
                                 client_valid, client_data, e.valid, e.data);
                    end
                end
                total++;
                if (prev_valid !== 3'b000) begin
                    bad++;
                    $display("[TB] FAIL sb_pulse_width: valid=%b after %b, required single cycle",
                             client_valid, prev_valid);
                end
            end
        end
        prev_valid = (reset === 1'b1) ? 3'b000 : client_valid;
    end

    function automatic logic [23:0] base_of(input int c);
        case (c)
            0:       return B0;
            1:       return B1;
            default: return B2;
        endcase
    endfunction

    function automatic logic [19:0] rr_addr(input int c, input int r);
        return 20'h00010 + 20'(r << 8) + 20'((2 - c) << 4);
    endfunction

    task automatic set_addr(input int c, input logic [19:0] a);
        client_addr[c*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        client_req = 3'b000;
        w_req      = 3'b000;
        sdram_ack  = 1'b0;
        w_sack     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sdram_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the negedge where the response (if any) is visible.
    task automatic do_ack(input logic [31:0] d);
        @(negedge clk);
        sdram_data = d;
        sdram_ack  = 1'b1;
        @(negedge clk);
        sdram_ack  = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        client_req  = 3'b000;
        client_addr = '0;
        sdram_data  = 32'd0;
        sdram_ack   = 1'b0;
        w_req       = 3'b000;
        w_addr      = '0;
        w_sdata     = 32'd0;
        w_sack      = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sdram_req !== 1'b0 || sdram_addr !== 24'd0) begin
            bad++;
            $display("[TB] FAIL reset_sdram: req=%b addr=%h, required 0/000000", sdram_req, sdram_addr);
        end
        total++;
        if (client_valid !== 3'b000 || client_data !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_client: valid=%b data=%h, required 000/00000000",
                     client_valid, client_data);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        total++;
        if (sdram_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle: sdram_req=%b, required 0", sdram_req);
        end
    endtask

    task automatic test_single();
        client_req = 3'b001;
        set_addr(0, 20'h00123);
        @(negedge clk);
        total++;
        if (sdram_req !== 1'b1 || sdram_addr !== 24'h000123) begin
            bad++;
            $display("[TB] FAIL single_issue: req=%b addr=%h, required 1/000123", sdram_req, sdram_addr);
        end
        repeat (2) @(negedge clk);
        total++;
        if (sdram_req !== 1'b1 || sdram_addr !== 24'h000123) begin
            bad++;
            $display("[TB] FAIL single_hold: req=%b addr=%h, required 1/000123", sdram_req, sdram_addr);
        end
        exp_q.push_back('{valid: 3'b001, data: 32'hDEADBEEF});
        do_ack(32'hDEADBEEF);
        total++;
        if (client_valid !== 3'b001 || client_data !== 32'hDEADBEEF || sdram_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_resp: valid=%b data=%h req=%b, required 001/DEADBEEF/0",
                     client_valid, client_data, sdram_req);
        end
        @(negedge clk);
        total++;
        if (client_valid !== 3'b000) begin
            bad++;
            $display("[TB] FAIL single_pulse_end: valid=%b, required 000", client_valid);
        end
    endtask

    task automatic test_held();
        bit seen = 1'b0;
        bit ok;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdram_req !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL held_reissue: sdram_req seen=1, required 0");
        end
        set_addr(0, 20'h00124);
        wait_req(ok);
        total++;
        if (!ok || sdram_addr !== 24'h000124) begin
            bad++;
            $display("[TB] FAIL held_new_addr: ok=%b addr=%h, required 1/000124", ok, sdram_addr);
        end
        exp_q.push_back('{valid: 3'b001, data: 32'h12345678});
        do_ack(32'h12345678);
        client_req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit ok;
        int c;
        int r;
        logic [23:0] ea;
        apply_reset();
        for (int i = 0; i < 3; i++) set_addr(i, rr_addr(i, 0));
        client_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            c  = k % 3;
            r  = k / 3;
            ea = base_of(c) + 24'(rr_addr(c, r));
            wait_req(ok);
            total++;
            if (!ok || sdram_addr !== ea) begin
                bad++;
                $display("[TB] FAIL rr_grant%0d: ok=%b addr=%h, required 1/%h", k, ok, sdram_addr, ea);
            end
            repeat (2) @(negedge clk);
            exp_q.push_back('{valid: 3'(1 << c), data: 32'hA0000000 + 32'(k)});
            do_ack(32'hA0000000 + 32'(k));
            total++;
            if (client_valid !== 3'(1 << c)) begin
                bad++;
                $display("[TB] FAIL rr_valid%0d: valid=%b, required %b", k, client_valid, 3'(1 << c));
            end
            set_addr(c, rr_addr(c, r + 1));
        end
        client_req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_withdrawal();
        bit ok;
        apply_reset();
        client_req = 3'b010;
        set_addr(1, 20'h00055);
        wait_req(ok);
        total++;
        if (!ok || sdram_addr !== 24'h100055) begin
            bad++;
            $display("[TB] FAIL wd_issue: ok=%b addr=%h, required 1/100055", ok, sdram_addr);
        end
        set_addr(0, 20'h00077);
        client_req = 3'b001;
        do_ack(32'hBAD0BAD0);
        total++;
        if (client_valid !== 3'b000 || sdram_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wd_discard: valid=%b req=%b, required 000/0", client_valid, sdram_req);
        end
        wait_req(ok);
        total++;
        if (!ok || sdram_addr !== 24'h000077) begin
            bad++;
            $display("[TB] FAIL wd_next: ok=%b addr=%h, required 1/000077", ok, sdram_addr);
        end
        exp_q.push_back('{valid: 3'b001, data: 32'hC0FFEE01});
        do_ack(32'hC0FFEE01);
        client_req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        bit ok;
        bit seen = 1'b0;
        client_req = 3'b100;
        set_addr(2, 20'h00099);
        wait_req(ok);
        total++;
        if (!ok || sdram_addr !== 24'h200099) begin
            bad++;
            $display("[TB] FAIL rst_issue: ok=%b addr=%h, required 1/200099", ok, sdram_addr);
        end
        reset = 1'b1;
        #1;
        total++;
        if (sdram_req !== 1'b0 || client_valid !== 3'b000) begin
            bad++;
            $display("[TB] FAIL rst_async: req=%b valid=%b, required 0/000", sdram_req, client_valid);
        end
        client_req = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sdram_data = 32'hFEEDFACE;
        sdram_ack  = 1'b1;
        @(negedge clk);
        sdram_ack  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (client_valid !== 3'b000 || sdram_req !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL rst_stray_ack: activity seen=1, required none");
        end
    endtask

    task automatic test_base_wrap();
        bit ok = 1'b0;
        w_req = 3'b100;
        w_addr[2*ADDR_W +: ADDR_W] = 20'h00020;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_sreq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || w_saddr !== 24'h000010) begin
            bad++;
            $display("[TB] FAIL wrap_addr: ok=%b addr=%h, required 1/000010", ok, w_saddr);
        end
        @(negedge clk);
        w_sdata = 32'h5A5A1234;
        w_sack  = 1'b1;
        @(negedge clk);
        w_sack  = 1'b0;
        total++;
        if (w_valid !== 3'b100 || w_cdata !== 32'h5A5A1234) begin
            bad++;
            $display("[TB] FAIL wrap_resp: valid=%b data=%h, required 100/5A5A1234", w_valid, w_cdata);
        end
        w_req = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting rom_req_arbiter bench");
        test_reset();
        test_single();
        test_held();
        test_round_robin();
        test_withdrawal();
        test_reset_midop();
        test_base_wrap();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL sb_leftover: pending=%0d, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
